// File: rtl/chn_ep_arb_pkg.sv
// Shared definitions for the endpoint arbiter: state encoding, defaults, pointer sizing.
package chn_ep_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int TMO_DEF  = 8;
  localparam int TAGW_DEF = 5;

  // Index width for an n-entry pointer; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chn_ep_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit scanning upward from ptr+1 with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // Walk farthest-first so the nearest requester after ptr overwrites last.
    for (int i = N; i >= 1; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/chn_ep_arb.sv
// Shares the TRN tx interface between NCHN channels via a token grant, and owns the non-posted tag counter.
module chn_ep_arb
  import chn_ep_arb_pkg::*;
#(
  parameter int NCHN = 2,
  parameter int TMO  = TMO_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCHN-1:0] chn_reqep,
  input  logic [NCHN-1:0] chn_drvn,
  input  logic [NCHN-1:0] tag_inc,
  output logic [NCHN-1:0] chn_trn,
  output logic [TAGW-1:0] tag_trn,
  output logic            ep_busy,
  output logic            arb_err
);

  localparam int PW = ptr_w(NCHN);
  localparam int CW = $clog2(TMO);

  arb_state_e      state, state_nx;
  logic [PW-1:0]   sel, rr_ptr, pick_idx;
  logic            pick_vld;
  logic [CW-1:0]   tmo_cnt;
  logic [NCHN-1:0] sel_oh, own_mask;
  logic            has_grant, tmo_fire, tmo_inc, viol;

  rr_pick #(.N(NCHN), .PW(PW)) u_pick (
    .req   (chn_reqep),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign ep_busy = (state != IDLE);

  always_comb begin
    sel_oh    = NCHN'(1) << sel;
    has_grant = (state == GRANT) || (state == OWN);
    own_mask  = has_grant ? sel_oh : '0;
    // Foreign drvn, drvn with nobody granted, or tag_inc from anyone but the live grantee.
    viol = ((state == IDLE) ? |chn_drvn : |(chn_drvn & ~sel_oh)) |
           |(tag_inc & ~own_mask);
  end

  always_comb begin
    state_nx = state;
    tmo_fire = 1'b0;
    tmo_inc  = 1'b0;
    case (state)
      IDLE:    if (pick_vld) state_nx = GRANT;
      GRANT: begin
        if (chn_drvn[sel])                      state_nx = OWN;
        else if (!chn_reqep[sel])               state_nx = RELEASE;
        else if (tmo_cnt == CW'(TMO - 1)) begin
          state_nx = RELEASE;
          tmo_fire = 1'b1;
        end
        else                                    tmo_inc  = 1'b1;
      end
      OWN:     if (!chn_drvn[sel]) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      rr_ptr  <= PW'(NCHN - 1);
      tmo_cnt <= '0;
      chn_trn <= '0;
      tag_trn <= '0;
      arb_err <= 1'b0;
    end else begin
      state   <= state_nx;
      arb_err <= viol | tmo_fire;
      if (state == IDLE && pick_vld) begin
        sel     <= pick_idx;
        rr_ptr  <= pick_idx;
        chn_trn <= NCHN'(1) << pick_idx;
        tmo_cnt <= '0;
      end
      if (state_nx == RELEASE) chn_trn <= '0;
      if (tmo_inc) tmo_cnt <= tmo_cnt + CW'(1);
      if (has_grant && tag_inc[sel]) tag_trn <= tag_trn + TAGW'(1);
    end
  end

endmodule

// File: tb/tb_chn_ep_arb.sv
// Directed bench for chn_ep_arb (NCHN=2, TMO=8): vector table plus multi-cycle sequences.
module tb_chn_ep_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] chn_reqep = '0, chn_drvn = '0, tag_inc = '0;
  logic [1:0] chn_trn;
  logic [4:0] tag_trn;
  logic       ep_busy, arb_err;

  int n_chk = 0;
  int n_err = 0;

  chn_ep_arb #(.NCHN(2), .TMO(8), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .chn_reqep(chn_reqep), .chn_drvn(chn_drvn), .tag_inc(tag_inc),
    .chn_trn(chn_trn), .tag_trn(tag_trn), .ep_busy(ep_busy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] req, drvn, inc, trn;
    logic [4:0] tag;
    logic       busy, err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [1:0] req, logic [1:0] drvn, logic [1:0] inc,
                              logic [1:0] trn, logic [4:0] tag, logic busy, logic err);
    vec_t v;
    v.r = r; v.req = req; v.drvn = drvn; v.inc = inc;
    v.trn = trn; v.tag = tag; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] q, input logic [1:0] d, input logic [1:0] t);
    rst = r; chn_reqep = q; chn_drvn = d; tag_inc = t;
    @(posedge clk); #1;
    chk("onehot", {31'd0, ($countones(chn_trn) > 1)}, 32'd0);
  endtask

  task automatic chk_out(input string nm, input logic [1:0] trn, input logic busy, input logic err);
    chk({nm, ".trn"}, {30'd0, chn_trn}, {30'd0, trn});
    chk({nm, ".busy"}, {31'd0, ep_busy}, {31'd0, busy});
    chk({nm, ".err"}, {31'd0, arb_err}, {31'd0, err});
  endtask

  initial begin
    int errs;
    logic [1:0] g;

    // Single grant lifecycle, then withdraw and drvn/withdraw collision, then an IDLE violation.
    tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 5'd0, 1, 0));
    for (int i = 0; i < 10; i++) tv.push_back(mk(0, 2'b01, 2'b01, 2'b00, 2'b01, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 0, 0));
    tv.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b10, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b10, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b10, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 0, 0));
    tv.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b01, 2'b00, 2'b01, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b01, 2'b00, 2'b01, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 1, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 0, 0));
    tv.push_back(mk(0, 2'b00, 2'b10, 2'b00, 2'b00, 5'd0, 0, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 0, 0));

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].req, tv[i].drvn, tv[i].inc);
      chk_out($sformatf("vec%0d", i), tv[i].trn, tv[i].busy, tv[i].err);
      chk($sformatf("vec%0d.tag", i), {27'd0, tag_trn}, {27'd0, tv[i].tag});
    end

    // Both channels requesting: grants alternate with one RELEASE dead cycle, then IDLE.
    step(1, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      step(0, 2'b11, 2'b00, 2'b00);
      chk_out($sformatf("alt%0d.grant", k), g, 1, 0);
      for (int c = 0; c < 4; c++) begin
        step(0, 2'b11, g, 2'b00);
        chk_out($sformatf("alt%0d.own%0d", k, c), g, 1, 0);
      end
      step(0, 2'b11, 2'b00, 2'b00);
      chk_out($sformatf("alt%0d.rel", k), 2'b00, 1, 0);
      step(0, 2'b11, 2'b00, 2'b00);
      chk_out($sformatf("alt%0d.idle", k), 2'b00, 0, 0);
    end

    // Grantee never drives: 8 cycles of grant, error on the revoking edge, other channel next.
    step(1, 2'b00, 2'b00, 2'b00);
    step(0, 2'b11, 2'b00, 2'b00);
    chk_out("tmo.grant", 2'b01, 1, 0);
    for (int c = 0; c < 7; c++) begin
      step(0, 2'b11, 2'b00, 2'b00);
      chk_out($sformatf("tmo.hold%0d", c), 2'b01, 1, 0);
    end
    step(0, 2'b11, 2'b00, 2'b00);
    chk_out("tmo.revoke", 2'b00, 1, 1);
    step(0, 2'b11, 2'b00, 2'b00);
    chk_out("tmo.idle", 2'b00, 0, 0);
    step(0, 2'b11, 2'b00, 2'b00);
    chk_out("tmo.next", 2'b10, 1, 0);

    // Tag counter: 33 grantee pulses wrap to 1; 3 foreign pulses each raise one error.
    step(1, 2'b00, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00, 2'b00);
    step(0, 2'b01, 2'b01, 2'b00);
    chk_out("tag.own", 2'b01, 1, 0);
    errs = 0;
    for (int i = 0; i < 36; i++) begin
      step(0, 2'b01, 2'b01, (i % 12 == 5) ? 2'b10 : 2'b01);
      if (arb_err) errs++;
      if (i == 0) chk("tag.first", {27'd0, tag_trn}, 32'd1);
    end
    chk("tag.wrap", {27'd0, tag_trn}, 32'd1);
    chk("tag.errs", errs, 32'd3);
    chk_out("tag.held", 2'b01, 1, 0);

    // Reset in OWN with tag 7: everything clears and channel 0 wins again.
    for (int i = 0; i < 6; i++) step(0, 2'b01, 2'b01, 2'b01);
    step(0, 2'b01, 2'b01, 2'b00);
    chk("rst.tag7", {27'd0, tag_trn}, 32'd7);
    step(1, 2'b01, 2'b01, 2'b00);
    chk_out("rst.clr", 2'b00, 0, 0);
    chk("rst.tag", {27'd0, tag_trn}, 32'd0);
    step(0, 2'b11, 2'b00, 2'b00);
    chk_out("rst.regrant", 2'b01, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/chn_ep_arb.md
Name: chn_ep_arb

Overview:
- Top-level PCIe endpoint arbiter that shares the single TRN tx interface between NCHN channel instances, each of which contains its own tx/rx/irq arbitration.
- Grants one channel at a time using the chn_trn / chn_reqep / chn_drvn token protocol, with round-robin fairness.
- Owns the shared 5-bit non-posted tag counter (tag_trn / tag_inc).
- Sits in pcie_clk domain beside the endpoint core; channel trn_t* outputs are OR-combined outside this block.

Parameters:
- NCHN, 2, number of channels arbitrated (2..8).
- TMO, 8, cycles a grantee may hold chn_trn without asserting chn_drvn before revocation (>=2).
- TAGW, 5, tag counter width.

Ports:
- clk  in  1  pcie_clk.
- rst  in  1  synchronous, active-high reset.
- chn_reqep  in  NCHN  per-channel endpoint request (level).
- chn_drvn  in  NCHN  per-channel "driving endpoint" indication (level).
- tag_inc  in  NCHN  per-channel single-cycle tag consumed pulse.
- chn_trn  out  NCHN  one-hot/zero grant (registered).
- tag_trn  out  TAGW  current free tag (registered).
- ep_busy  out  1  high in any state other than IDLE.
- arb_err  out  1  single-cycle pulse on protocol violation or timeout.

Behaviour:
- Reset values: chn_trn=0, tag_trn=0, ep_busy=0, arb_err=0, state=IDLE, rr_ptr=NCHN-1 (channel 0 wins the first arbitration), tmo_cnt=0.
- Clock and reset: one clock; reset is synchronous and active-high. Reset asserted mid-grant drops chn_trn the next cycle, with no arb_err.
- FSM states: IDLE, GRANT, OWN, RELEASE.
- IDLE:
  - If any chn_reqep is high, pick the first requester scanning from rr_ptr+1 (mod NCHN), upward with wrap.
  - Register sel, set chn_trn[sel] and rr_ptr=sel, clear tmo_cnt, go to GRANT.
  - Latency: reqep sampled at edge n -> chn_trn high after edge n.
- GRANT:
  - If chn_drvn[sel]=1 -> OWN.
  - Else if chn_reqep[sel]=0 (requester withdrew) -> RELEASE, no error.
  - Else if tmo_cnt==TMO-1 -> RELEASE and pulse arb_err.
  - Otherwise tmo_cnt++.
  - drvn takes priority over withdraw and timeout when they occur in the same cycle.
- OWN:
  - chn_trn[sel] is held. When chn_drvn[sel] is sampled low -> RELEASE.
  - chn_reqep is ignored in OWN.
- RELEASE:
  - chn_trn=0 for exactly one dead cycle (bus turnaround), then IDLE.
  - drvn low sampled at edge n -> chn_trn=0 from n+1. Earliest next grant is visible after edge n+2.
- Grant invariant: chn_trn has at most one bit set at all times and is never high in IDLE or RELEASE.
- Violation: any chn_drvn[i] high with i!=sel, or any drvn while in IDLE -> arb_err pulse each cycle it persists. The grant is unaffected.
- Tag counter:
  - tag_trn increments by 1 (mod 2^TAGW, so 31->0 wraps) on a cycle where state is GRANT or OWN and tag_inc[sel]=1.
  - tag_inc from non-grantees is ignored and raises arb_err.
  - The new value is visible the cycle after the pulse.
  - Back-to-back pulses increment on every cycle.
- Fairness: a continuously requesting channel is granted within NCHN-1 other grants.

Decomposition:
- Package chn_ep_arb_pkg holds:
  - state encoding (IDLE, GRANT, OWN, RELEASE as localparams, 2 bits);
  - default TMO and TAGW;
  - a function for log2(NCHN) pointer width.
- One natural sub-module is rr_pick: combinational round-robin priority encoder with inputs req[NCHN] and ptr, and outputs valid and idx. It is reused by the per-channel tx/rx/irq arbiter cleanup.

Test Plan:
- Reset, then reqep=2'b01 held, drvn[0] raised 2 cycles after grant for 10 cycles, then dropped -> chn_trn=01 one cycle after reqep; held through OWN; 00 one cycle after drvn falls; ep_busy low two cycles after drvn falls; no arb_err.
- Both channels request continuously, each holding drvn 4 cycles per grant -> grants alternate 01,10,01,10 with exactly one dead RELEASE cycle between a grant dropping and the next IDLE cycle; never two bits set.
- Grantee never asserts drvn, TMO=8 -> chn_trn high exactly 8 cycles; arb_err single pulse on the revoking edge; the other requester is granted next.
- During OWN, grantee pulses tag_inc 33 times, plus 3 tag_inc pulses from the non-grantee -> tag_trn ends at 1 (wrapped); 3 arb_err pulses.
- Reset asserted while in OWN with tag_trn=7 -> next cycle chn_trn=0, tag_trn=0, state IDLE; the following request goes to channel 0.
- Grantee drops reqep in GRANT at cycle 3 with drvn low -> RELEASE with no arb_err; drvn and withdraw in the same cycle -> OWN.
